// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the accumulator datapath: fetch/decode/execute
// sequencing, memory write strobe and the multiply-by-two handshake.
module cpu_ctrl_fsm #(
    parameter int unsigned MUL_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] opcode,
    input  logic       zflag,
    input  logic       mullDone,
    output logic       muxPC,
    output logic       muxMAR,
    output logic       muxACC,
    output logic       loadPC,
    output logic       loadMAR,
    output logic       loadMDR,
    output logic       loadIR,
    output logic       loadACC,
    output logic       opALU,
    output logic       mullACC,
    output logic       mem_we,
    output logic       halted,
    output logic [1:0] err
);
    // state | meaning
    // IDLE  | waiting for run
    // F1    | MAR <= PC
    // F2    | MDR <= mem[MAR]
    // F3    | IR <= MDR, PC <= PC+1
    // DEC   | decode live opcode, latch it
    // EA    | MAR <= IR[15:8]
    // RD    | MDR <= mem[MAR]
    // EX    | ACC load / add / sub
    // WR    | mem[MAR] <= ACC
    // JMP   | PC <= IR
    // MUL   | multiply request, bounded wait for mullDone
    // HALT  | stopped until rst
    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DEC, S_EA, S_RD, S_EX, S_WR, S_JMP, S_MUL, S_HALT
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JZ    = 8'h06;
    localparam logic [7:0] OP_MUL2  = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_MUL_TO  = 2'b10;

    localparam logic [7:0] MUL_LAST = 8'(MUL_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= 8'd0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_F3;
            S_F3:   state_d = S_DEC;
            S_DEC: begin
                op_d  = opcode;
                cnt_d = 8'd0;
                case (opcode)
                    OP_NOP:                           state_d = S_F1;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_d = S_EA;
                    OP_JMP:                           state_d = S_JMP;
                    OP_JZ:                            state_d = zflag ? S_JMP : S_F1;
                    OP_MUL2:                          state_d = S_MUL;
                    OP_HALT:                          state_d = S_HALT;
                    default: begin
                        state_d = S_HALT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EA:  state_d = (op_q == OP_STORE) ? S_WR : S_RD;
            S_RD:  state_d = S_EX;
            S_EX:  state_d = S_F1;
            S_WR:  state_d = S_F1;
            S_JMP: state_d = S_F1;
            S_MUL: begin
                // mullDone wins even on the final allowed cycle
                if (mullDone) begin
                    state_d = S_F1;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = S_HALT;
                    err_d   = ERR_MUL_TO;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        muxPC   = 1'b0;
        muxMAR  = 1'b0;
        muxACC  = 1'b0;
        loadPC  = 1'b0;
        loadMAR = 1'b0;
        loadMDR = 1'b0;
        loadIR  = 1'b0;
        loadACC = 1'b0;
        opALU   = 1'b0;
        mullACC = 1'b0;
        mem_we  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            S_F1: begin
                loadMAR = 1'b1;
                muxMAR  = 1'b1;
            end
            S_F2: loadMDR = 1'b1;
            S_F3: begin
                loadIR = 1'b1;
                loadPC = 1'b1;
            end
            S_EA: loadMAR = 1'b1;
            S_RD: loadMDR = 1'b1;
            S_EX: begin
                loadACC = 1'b1;
                muxACC  = (op_q == OP_LOAD);
                opALU   = (op_q == OP_SUB);
            end
            S_WR: mem_we = 1'b1;
            S_JMP: begin
                loadPC = 1'b1;
                muxPC  = 1'b1;
            end
            S_MUL:  mullACC = 1'b1;
            S_HALT: halted  = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: a small datapath around the controller, directed
// programs plus random forward-only programs checked against an ISA-level model.
module tb_cpu_ctrl_fsm;
    localparam int MT = 16;

    localparam logic [11:0] C_F1    = 12'h480;
    localparam logic [11:0] C_F2    = 12'h040;
    localparam logic [11:0] C_F3    = 12'h120;
    localparam logic [11:0] C_DEC   = 12'h000;
    localparam logic [11:0] C_EA    = 12'h080;
    localparam logic [11:0] C_RD    = 12'h040;
    localparam logic [11:0] C_EXL   = 12'h210;
    localparam logic [11:0] C_EXA   = 12'h010;
    localparam logic [11:0] C_WR    = 12'h002;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] opcode;
    logic       zflag;
    logic       mullDone = 1'b0;
    logic muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC;
    logic opALU, mullACC, mem_we, halted;
    logic [1:0] err;
    logic [11:0] ctrl_v;

    cpu_ctrl_fsm #(.MUL_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zflag(zflag),
        .mullDone(mullDone), .muxPC(muxPC), .muxMAR(muxMAR), .muxACC(muxACC),
        .loadPC(loadPC), .loadMAR(loadMAR), .loadMDR(loadMDR), .loadIR(loadIR),
        .loadACC(loadACC), .opALU(opALU), .mullACC(mullACC), .mem_we(mem_we),
        .halted(halted), .err(err)
    );

    assign ctrl_v = {muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR,
                     loadACC, opALU, mullACC, mem_we, halted};

    // datapath model: word = {addr, opcode} for instructions, plain data otherwise
    logic [7:0]  pc, mar;
    logic [15:0] mdr, ir, acc;
    logic [15:0] mem [256];
    logic [15:0] prog [256];
    logic        dp_clr = 1'b1;

    assign opcode = ir[7:0];

    always @(posedge clk) begin
        if (dp_clr) begin
            pc <= 8'd0; mar <= 8'd0; mdr <= 16'd0; ir <= 16'd0; acc <= 16'd0;
            zflag <= 1'b1;
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else begin
            zflag <= (acc == 16'd0);
            if (loadMAR) mar <= muxMAR ? pc : ir[15:8];
            if (loadMDR) mdr <= mem[mar];
            if (loadIR)  ir  <= mdr;
            if (loadPC)  pc  <= muxPC ? ir[15:8] : pc + 8'd1;
            if (loadACC) acc <= muxACC ? mdr : (opALU ? acc - mdr : acc + mdr);
            else if (mullACC && mullDone) acc <= acc << 1;
            if (mem_we) mem[mar] <= acc;
        end
    end

    // multiplier responder: k-th MUL cycle of occurrence j raises mullDone when k == mul_k[j]
    int   mul_k [64];
    int   mul_idx = 0, mul_cnt = 0, mul_cycles = 0, excl_viol = 0;
    logic mul_clr = 1'b1;

    always @(negedge clk) begin
        if (mul_clr) begin
            mul_idx = 0; mul_cnt = 0; mul_cycles = 0; mullDone = 1'b0;
        end else if (mullACC) begin
            mul_cnt++;
            mul_cycles++;
            mullDone = (mul_cnt == mul_k[mul_idx[5:0]]);
        end else begin
            if (mul_cnt != 0) mul_idx++;
            mul_cnt = 0;
            mullDone = 1'b0;
        end
        if ((loadACC && mullACC) ||
            (mem_we && (loadPC || loadMAR || loadMDR || loadIR || loadACC)) ||
            (halted && ctrl_v[11:1] != 11'd0))
            excl_viol++;
    end

    int n_err = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [11:0] trace [64];

    task automatic start_prog();
        rst = 1'b1; run = 1'b0; dp_clr = 1'b1; mul_clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {20'd0, ctrl_v}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        dp_clr = 1'b0; mul_clr = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("idle_ctrl", {20'd0, ctrl_v}, 32'd0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("f1_ctrl", {20'd0, ctrl_v}, {20'd0, C_F1});
    endtask

    task automatic run_prog(output int cyc);
        start_prog();
        cyc = 0;
        while (!halted && cyc < 600) begin
            if (cyc < 64) trace[cyc] = ctrl_v;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        for (int i = 0; i < 64; i++) mul_k[i] = 0;
    endtask

    // ISA-level reference: executes instructions, sums per-instruction cycle costs
    logic [15:0] mm [256];
    logic [15:0] m_acc;
    logic [7:0]  m_pc;
    logic [1:0]  m_err;
    int          m_cyc, m_mulc;

    task automatic model_run();
        logic [15:0] w;
        logic [7:0]  a;
        int          mi, k;
        bit          done;
        for (int i = 0; i < 256; i++) mm[i] = prog[i];
        m_acc = 16'd0; m_pc = 8'd0; m_err = 2'b00; m_cyc = 0; m_mulc = 0;
        mi = 0; done = 1'b0;
        for (int s = 0; s < 300 && !done; s++) begin
            w = mm[m_pc];
            a = w[15:8];
            m_pc = m_pc + 8'd1;
            case (w[7:0])
                8'h00: m_cyc += 4;
                8'h01: begin m_acc = mm[a]; m_cyc += 7; end
                8'h02: begin mm[a] = m_acc; m_cyc += 6; end
                8'h03: begin m_acc = m_acc + mm[a]; m_cyc += 7; end
                8'h04: begin m_acc = m_acc - mm[a]; m_cyc += 7; end
                8'h05: begin m_pc = a; m_cyc += 5; end
                8'h06: if (m_acc == 16'd0) begin m_pc = a; m_cyc += 5; end
                       else m_cyc += 4;
                8'h07: begin
                    k = mul_k[mi]; mi++;
                    if (k >= 1 && k <= MT) begin
                        m_acc = m_acc * 16'd2; m_cyc += 4 + k; m_mulc += k;
                    end else begin
                        m_cyc += 4 + MT; m_mulc += MT; m_err = 2'b10; done = 1'b1;
                    end
                end
                8'hFF: begin m_cyc += 4; done = 1'b1; end
                default: begin m_cyc += 4; m_err = 2'b01; done = 1'b1; end
            endcase
        end
    endtask

    initial begin
        int cyc, mism, n, r;
        logic [11:0] exp_tr [24];
        logic [7:0]  opc;

        // LOAD/ADD/STORE/HALT with per-cycle control trace
        clear_prog();
        prog[0] = 16'h1001; prog[1] = 16'h1103; prog[2] = 16'h1202; prog[3] = 16'h00FF;
        prog[8'h10] = 16'd5; prog[8'h11] = 16'd3;
        run_prog(cyc);
        chk("p1_cycles", cyc, 24);
        chk("p1_acc", {16'd0, acc}, 32'd8);
        chk("p1_mem12", {16'd0, mem[8'h12]}, 32'd8);
        chk("p1_halted", {31'd0, halted}, 32'd1);
        chk("p1_err", {30'd0, err}, 32'd0);
        exp_tr = '{C_F1, C_F2, C_F3, C_DEC, C_EA, C_RD, C_EXL,
                   C_F1, C_F2, C_F3, C_DEC, C_EA, C_RD, C_EXA,
                   C_F1, C_F2, C_F3, C_DEC, C_EA, C_WR,
                   C_F1, C_F2, C_F3, C_DEC};
        mism = 0;
        for (int i = 0; i < 24; i++) if (trace[i] !== exp_tr[i]) mism++;
        chk("p1_trace", mism, 0);

        // JZ taken with ACC=0
        clear_prog();
        prog[0] = 16'h2006; prog[8'h20] = 16'h00FF;
        run_prog(cyc);
        chk("jz_t_cycles", cyc, 9);
        chk("jz_t_pc", {24'd0, pc}, 32'h21);

        // JZ not taken with ACC=1
        clear_prog();
        prog[0] = 16'h1001; prog[1] = 16'h2006; prog[2] = 16'h00FF; prog[8'h10] = 16'd1;
        run_prog(cyc);
        chk("jz_nt_cycles", cyc, 15);
        chk("jz_nt_pc", {24'd0, pc}, 32'd3);

        // MUL2 with ACC=6, mullDone on the 3rd MUL cycle
        clear_prog();
        prog[0] = 16'h1001; prog[1] = 16'h0007; prog[2] = 16'h00FF; prog[8'h10] = 16'd6;
        mul_k[0] = 3;
        run_prog(cyc);
        chk("mul_cycles", cyc, 18);
        chk("mul_acc", {16'd0, acc}, 32'd12);
        chk("mul_req_cycles", mul_cycles, 3);
        chk("mul_err", {30'd0, err}, 32'd0);

        // MUL2 timeout
        clear_prog();
        prog[0] = 16'h0007; prog[1] = 16'h00FF;
        run_prog(cyc);
        chk("mto_cycles", cyc, 4 + MT);
        chk("mto_err", {30'd0, err}, 32'd2);
        chk("mto_req_cycles", mul_cycles, MT);

        // illegal opcode, then nothing moves in HALT
        clear_prog();
        prog[0] = 16'h0042; prog[1] = 16'h1001; prog[8'h10] = 16'd9;
        run_prog(cyc);
        chk("ill_cycles", cyc, 4);
        chk("ill_err", {30'd0, err}, 32'd1);
        repeat (5) @(negedge clk);
        chk("ill_pc", {24'd0, pc}, 32'd1);
        chk("ill_acc", {16'd0, acc}, 32'd0);
        chk("ill_halted", {31'd0, halted}, 32'd1);

        // reset during RD of an ADD
        clear_prog();
        prog[0] = 16'h1001; prog[1] = 16'h1103; prog[2] = 16'h00FF;
        prog[8'h10] = 16'd5; prog[8'h11] = 16'd3;
        start_prog();
        repeat (12) @(negedge clk);
        chk("rd_ctrl", {20'd0, ctrl_v}, {20'd0, C_RD});
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {20'd0, ctrl_v}, 32'd0);
        @(negedge clk);
        chk("rst_mid_acc", {16'd0, acc}, 32'd5);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_idle", {20'd0, ctrl_v}, 32'd0);
        chk("rst_mid_acc2", {16'd0, acc}, 32'd5);

        // random forward-only programs against the ISA model
        for (int t = 0; t < 25; t++) begin
            clear_prog();
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                case (r)
                    0, 1:        opc = 8'h00;
                    2, 3, 4:     opc = 8'h01;
                    5, 6:        opc = 8'h02;
                    7, 8, 9:     opc = 8'h03;
                    10, 11:      opc = 8'h04;
                    12:          opc = 8'h05;
                    13, 14:      opc = 8'h06;
                    15, 16, 17:  opc = 8'h07;
                    18:          opc = 8'($urandom_range(8, 254));
                    default:     opc = 8'h00;
                endcase
                if (opc == 8'h05 || opc == 8'h06)
                    prog[i] = {8'($urandom_range(i + 1, n)), opc};
                else
                    prog[i] = {8'($urandom_range(8'h80, 8'h8F)), opc};
            end
            prog[n] = 16'h00FF;
            for (int a = 8'h80; a <= 8'h8F; a++) prog[a] = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 500));
            for (int j = 0; j < 64; j++) begin
                r = $urandom_range(0, 9);
                mul_k[j] = (r == 0) ? 0 : (r == 1) ? 20 : (r == 2) ? MT : $urandom_range(1, 5);
            end
            model_run();
            run_prog(cyc);
            chk("rnd_cycles", cyc, m_cyc);
            chk("rnd_acc", {16'd0, acc}, {16'd0, m_acc});
            chk("rnd_pc", {24'd0, pc}, {24'd0, m_pc});
            chk("rnd_err", {30'd0, err}, {30'd0, m_err});
            chk("rnd_halted", {31'd0, halted}, 32'd1);
            chk("rnd_mul_req", mul_cycles, m_mulc);
            mism = 0;
            for (int a = 0; a < 256; a++) if (mem[a] !== mm[a]) mism++;
            chk("rnd_mem", mism, 0);
        end

        chk("excl_viol", excl_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control unit for the accumulator datapath. It fetches each instruction through PC/MAR/MDR/IR, decodes the 8-bit opcode and sequences the datapath's load, mux and ALU controls. It drives the memory write strobe and runs the multiply-by-two handshake with the datapath multiplier. It sits beside the datapath at the CPU top level and is the only block that drives its control inputs.

## Interface
- MUL_TIMEOUT, 16: maximum number of MUL-state cycles spent waiting for mullDone before an error halt; legal range 1-255.
- clk  in  1  clock; reset rst asynchronous, active-high.
- rst  in  1  asynchronous active-high reset.
- run  in  1  leave IDLE and start fetching; sampled only in IDLE.
- opcode  in  8  IR[7:0] from the datapath.
- zflag  in  1  datapath zero flag; lags ACC by one cycle.
- mullDone  in  1  multiplier result ready.
- muxPC, muxMAR, muxACC  out  1 each  datapath mux selects.
- loadPC, loadMAR, loadMDR, loadIR, loadACC  out  1 each  datapath register loads.
- opALU  out  1  0 = add, 1 = subtract.
- mullACC  out  1  multiply request; ACC takes the multiplier output.
- mem_we  out  1  memory write of MemD at MemAddr at the end of the cycle.
- halted  out  1  high in HALT.
- err  out  2  halt cause: 00 none, 01 illegal opcode, 10 multiply timeout; sticky until rst.

## Operation
- Opcodes: NOP 8'h00, LOAD 8'h01, STORE 8'h02, ADD 8'h03, SUB 8'h04, JMP 8'h05, JZ 8'h06, MUL2 8'h07, HALT 8'hFF. Every other value is illegal.
- States: IDLE, F1, F2, F3, DEC, EA, RD, EX, WR, JMP, MUL, HALT. Outputs are a Moore decode of the state; any output not listed below is 0.
- IDLE: all controls 0. If run=1, go to F1.
- F1: loadMAR=1, muxMAR=1 (MAR <= PC).
- F2: loadMDR=1.
- F3: loadIR=1, loadPC=1, muxPC=0 (PC <= PC+1).
- DEC: no controls asserted. Next state by opcode:
  - NOP goes to F1.
  - LOAD, STORE, ADD and SUB go to EA.
  - JMP goes to JMP.
  - JZ goes to JMP if zflag=1, otherwise to F1.
  - MUL2 goes to MUL.
  - HALT goes to HALT.
  - An illegal opcode goes to HALT and sets err=01.
- EA: loadMAR=1, muxMAR=0 (MAR <= IR[15:8]). STORE goes to WR; all others go to RD.
- RD: loadMDR=1, then EX.
- EX: loadACC=1. LOAD uses muxACC=1. ADD uses muxACC=0, opALU=0. SUB uses muxACC=0, opALU=1. Then F1.
- WR: mem_we=1, then F1.
- JMP: loadPC=1, muxPC=1 (PC <= IR), then F1.
- MUL: mullACC=1 with an internal wait counter.
  - If mullDone=1, go to F1; mullACC drops in that next state.
  - If the counter reaches MUL_TIMEOUT without mullDone, go to HALT with err=10.
  - The counter clears on every MUL entry.
- HALT: all controls 0, halted=1. Only rst exits HALT.
- The opcode is latched into an internal register on the DEC edge. EA, RD and EX use the latched copy, never the live input.
- Mutual exclusion: loadACC and mullACC are never high together. mem_we is never high together with any load.

## Timing
- rst asserted: state is IDLE immediately and asynchronously. All outputs are 0, err=00, the wait counter is 0.
- Reset mid-instruction abandons the instruction with no further loads or writes.
- Fetch is 4 cycles (F1-DEC).
- Instruction totals:
  - NOP and HALT: 4 cycles.
  - JZ not taken: 4 cycles.
  - JMP and JZ taken: 5 cycles.
  - STORE: 6 cycles.
  - LOAD, ADD and SUB: 7 cycles.
  - MUL2: 4 + k cycles, where k is the MUL cycle in which mullDone is first seen (k ≥ 1).
- run is sampled only in IDLE; it is ignored once running.
- zflag sampled in DEC reflects ACC as of at least 2 cycles earlier. The last ACC write is always at least 4 cycles before the next DEC, so no stall is needed.
- PC wrap-around (8'hFF+1 = 8'h00) is the datapath's concern; the controller does not detect it.

## Test plan
- Reset then run: rst high for 3 cycles, then run=1 → F1 on the next edge. Every control stays 0 while in reset and in IDLE.
- Program LOAD 8'h10 (mem[10]=5), ADD 8'h11 (mem[11]=3), STORE 8'h12, HALT → ACC=8, mem[12]=8, halted=1 at cycle 7+7+6+4. Each step's control vector matches its state.
- JZ taken vs not taken: ACC=0 then JZ 8'h20 → PC=8'h20, 5 cycles. ACC=1 → PC increments, 4 cycles.
- MUL2 with ACC=6 and mullDone high on the 3rd MUL cycle → mullACC high for exactly 3 cycles, ACC=12, total 7 cycles.
- MUL2 with mullDone held 0 → HALT after MUL_TIMEOUT cycles with err=10. Opcode 8'h42 → HALT with err=01, no loads after DEC.
- rst asserted during RD of an ADD → outputs 0 that same cycle, state IDLE, ACC not loaded.
